// File: rtl/seq_divider_32_if.sv
// seq_divider_32_if: start/operand/result bundle of the sequential divider.
interface seq_divider_32_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_32.sv
// seq_divider_32: unsigned restoring divider, one quotient bit per clock.
// rq holds {partial remainder, dividend/quotient} and shifts left each iteration.
module seq_divider_32 #(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    seq_divider_32_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_next;
    logic [2*WIDTH-1:0] rq, s, rq_next;
    logic [WIDTH:0]     t;
    logic [WIDTH-1:0]   dreg;
    logic [CW-1:0]      cnt;
    logic               dbz;
    logic               accept;
    logic               zero_div;

    assign accept   = (state != RUN) && bus.start;
    assign zero_div = (bus.divisor == '0);

    always_comb begin
        s          = rq << 1;
        t          = {1'b0, s[2*WIDTH-1:WIDTH]} - {1'b0, dreg};
        rq_next    = t[WIDTH] ? s : {t[WIDTH-1:0], s[WIDTH-1:1], 1'b1};
        state_next = state;
        case (state)
            IDLE, DONE: state_next = accept ? (zero_div ? DONE : RUN) : IDLE;
            RUN:        state_next = (cnt == CW'(1)) ? DONE : RUN;
            default:    state_next = IDLE;
        endcase
    end

    // A zero divisor skips iteration; the load itself produces the all-ones quotient.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rq    <= '0;
            dreg  <= '0;
            cnt   <= '0;
            dbz   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                rq   <= zero_div ? {bus.dividend, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, bus.dividend};
                dreg <= bus.divisor;
                cnt  <= CW'(WIDTH);
                dbz  <= zero_div;
            end else if (state == RUN) begin
                rq  <= rq_next;
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = rq[WIDTH-1:0];
    assign bus.remainder   = rq[2*WIDTH-1:WIDTH];
    assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_seq_divider_32.sv
// tb_seq_divider_32: table-driven directed checks of seq_divider_32 plus
// hand-written sequences for start-during-run, back-to-back and mid-run reset.
module tb_seq_divider_32;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    seq_divider_32_if #(.WIDTH(32)) bus ();
    seq_divider_32 dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic launch(input vec_t v);
        bus.start    = 1'b1;
        bus.dividend = v.a;
        bus.divisor  = v.b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
    endtask

    // Called in cycle k+1; returns in the expected done cycle after checking it.
    task automatic wait_done(input vec_t v, input int inj);
        int bad = 0;
        if (v.b != 0) begin
            for (int i = 0; i < 32; i++) begin
                if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
                bus.start = (i == inj);
                if (i == inj) begin
                    bus.dividend = 32'd50;
                    bus.divisor  = 32'd5;
                end
                @(posedge clk);
                #1;
            end
            bus.start = 1'b0;
            chk("busy_window", bad, 0);
        end
        chk("done_pulse", bus.done, 1);
        chk("busy_in_done", bus.busy, 0);
        chk("quotient", bus.quotient, v.q);
        chk("remainder", bus.remainder, v.r);
        chk("div_by_zero", bus.div_by_zero, v.z);
    endtask

    task automatic hold(input vec_t v);
        @(posedge clk);
        #1;
        chk("done_drop", bus.done, 0);
        chk("busy_idle", bus.busy, 0);
        chk("q_held", bus.quotient, v.q);
        chk("r_held", bus.remainder, v.r);
        chk("dbz_held", bus.div_by_zero, v.z);
    endtask

    initial begin
        vec_t vecs[7];
        vec_t v_run, v_b2b, v_small;
        int   bad;
        vecs[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0};
        vecs[3] = '{32'd5, 32'd9, 32'd0, 32'd5, 1'b0};
        vecs[4] = '{32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1};
        vecs[5] = '{32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2, 1'b0};
        vecs[6] = '{32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0};
        v_run   = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
        v_b2b   = '{32'd1000, 32'd33, 32'd30, 32'd10, 1'b0};
        v_small = '{32'd9, 32'd3, 32'd3, 32'd0, 1'b0};

        bus.start    = 1'b1;
        bus.dividend = 32'd77;
        bus.divisor  = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_q", bus.quotient, 0);
        chk("rst_r", bus.remainder, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[n]) begin
            launch(vecs[n]);
            wait_done(vecs[n], -1);
            hold(vecs[n]);
            repeat (2) @(posedge clk);
            #1;
        end

        // start mid-run is ignored
        launch(v_run);
        wait_done(v_run, 15);
        hold(v_run);

        // back-to-back: second start issued in the done cycle of the first
        launch(v_run);
        wait_done(v_run, -1);
        launch(v_b2b);
        wait_done(v_b2b, -1);
        hold(v_b2b);

        // reset at iteration 10 aborts with no done pulse
        launch(v_run);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_q", bus.quotient, 0);
        chk("abort_r", bus.remainder, 0);
        chk("abort_dbz", bus.div_by_zero, 0);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        chk("abort_quiet", bad, 0);
        launch(v_small);
        wait_done(v_small, -1);
        hold(v_small);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
